// File: rtl/hls_channel_pkg.sv
// Shared defaults and sizing helper for HLS inter-stage FIFO channels.
// No logic; constants and a pointer-width function only.
// Imported by the channel top and its storage.
package hls_channel_pkg;

    localparam int CHAN_WIDTH = 32;
    localparam int CHAN_DEPTH = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/hls_fifo_mem.sv
// Channel storage array: synchronous write, asynchronous read.
// Write lands at the clock edge; read data follows raddr with no register.
// No flow control here; the caller qualifies wen.
module hls_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hls_fifo_channel.sv
// FIFO channel between HLS stages with a registered pop-data output.
// Push-to-data is 3 edges minimum (push, pop, data valid); no bypass.
// write_ready/read_ready come from registered occupancy only; flush beats everything.
module hls_fifo_channel
    import hls_channel_pkg::*;
#(
    parameter int WIDTH = CHAN_WIDTH,
    parameter int DEPTH = CHAN_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   write_valid,
    output logic                   write_ready,
    input  logic                   read_valid,
    output logic                   read_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rdata;
    logic             do_push;
    logic             do_pop;

    assign write_ready = (cnt != CNT_FULL);
    assign read_ready  = (cnt != '0);
    assign count       = cnt;

    // Gating on the ready flags is what forbids bypass when empty and overwrite when full.
    assign do_push = write_valid && write_ready && !flush;
    assign do_pop  = read_valid && read_ready && !flush;

    hls_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .wen   (do_push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                out_data <= rdata;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: doc/hls_fifo_channel.md
Name: hls_fifo_channel

Overview:
- Synchronous FIFO channel that connects HLS-generated stages, e.g. the producer feeding a reducer's input channel and the reducer's output channel.
- Consumer side uses a ready/valid pop protocol with registered read data.
  - Consumer waits for read_ready, pulses read_valid, and samples out_data on the following cycle.
- Producer side uses write_ready and write_valid with in_data.
- flush is a synchronous clear, driven by the controller's per-channel reset output.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  Clock.
- rst  input  1  Reset; asynchronous, active-low.
- flush  input  1  Synchronous clear, active-high; the controller's per-channel rst output drives it.
- in_data  input  WIDTH  Write data.
- write_valid  input  1  Push request.
- write_ready  output  1  High when the FIFO is not full.
- read_valid  input  1  Pop request.
- read_ready  output  1  High when the FIFO is not empty.
- out_data  output  WIDTH  Registered pop data.
- count  output  $clog2(DEPTH)+1  Current occupancy.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - cnt, 0..DEPTH.
  - data register.
  - mem[DEPTH].
- Reset (rst low, asynchronous):
  - wr_ptr, rd_ptr, cnt and out_data all cleared to 0.
  - Therefore read_ready=0, write_ready=1, count=0.
  - mem contents are not reset.
- flush=1 at a clock edge:
  - Same clearing as reset, including out_data=0.
  - Any push or pop in that cycle is ignored.
  - flush has priority over all other activity.
- Status outputs:
  - write_ready = (cnt != DEPTH).
  - read_ready = (cnt != 0).
  - Both are derived combinationally from registered cnt only; there is no combinational path from valid inputs to ready outputs.
- Push:
  - Condition: write_valid && write_ready at the clock edge.
  - Action: mem[wr_ptr] <= in_data; wr_ptr increments.
  - write_valid while full is silently dropped.
- Pop:
  - Condition: read_valid && read_ready at the clock edge.
  - Action: out_data <= mem[rd_ptr]; rd_ptr increments.
  - Data is visible one cycle after read_valid and is held until the next successful pop, flush, or reset.
  - read_valid while empty is ignored; out_data is unchanged.
- Simultaneous push and pop in one cycle:
  - Both occur and cnt is unchanged.
  - Allowed only when the pre-edge cnt satisfies 0 < cnt < DEPTH.
- No bypass and no look-ahead:
  - When empty, a simultaneous push and pop performs only the push.
  - When full, a simultaneous push and pop performs only the pop.
- cnt update: +1 on push only, -1 on pop only, otherwise unchanged.
- Latency:
  - A pushed word first raises read_ready on the cycle after the push edge.
  - Minimum write-to-data latency is 3 edges: push, pop, data valid.
- Wrap-around: pointers wrap naturally at DEPTH. Ordering must stay strictly FIFO across the wrap.
- read_valid must not depend on out_data within the same cycle. Consumers hold read_valid for one cycle per word.
  - A held read_valid pops on every edge while non-empty; this behaviour is intended and verified.

Decomposition:
- Package hls_channel_pkg holds:
  - the default width constant CHAN_WIDTH=32;
  - the default depth constant CHAN_DEPTH=16;
  - function ptr_w(depth) = $clog2(depth).
- One sub-module, hls_fifo_mem:
  - parameters WIDTH and DEPTH;
  - synchronous write port (wen, waddr, wdata);
  - asynchronous read port (raddr, rdata);
  - no reset.
- Pointer, count and out_data logic lives in hls_fifo_channel.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst=0, then release.
  - Required: read_ready=0, write_ready=1, count=0, out_data=0. A read_valid pulse while empty leaves out_data=0 and count=0.
- Basic ordering:
  - Stimulus: push 5, 7, 9, 11, then issue four single-cycle read_valid pulses spaced 3 cycles apart.
  - Required: out_data equals 5, 7, 9, 11, each appearing the cycle after its pulse. read_ready falls after the 4th pop. A downstream 4-element reduce sum of 32.
- Full:
  - Stimulus: push 0..15; write_ready drops after the 16th push. Then push 99 while full.
  - Required: 99 is dropped and count stays 16. Popping 16 words returns 0..15 in order.
- Simultaneous push and pop:
  - Stimulus: with count=3, assert write_valid (data 0xA5) and read_valid in the same cycle.
  - Required: count stays 3, out_data equals the old head, and 0xA5 emerges after the 3 earlier words.
- Boundary no-bypass cases:
  - Stimulus: push and pop together while empty.
    - Required: count becomes 1 and out_data is unchanged.
  - Stimulus: push and pop together while full.
    - Required: count becomes 15 and the new word is dropped.
- Wrap, flush and reset mid-stream:
  - Stimulus: stream 40 words with interleaved pops.
    - Required: order is preserved across the pointer wrap.
  - Stimulus: flush with count=6.
    - Required: count=0, out_data=0, read_ready=0 next cycle.
  - Stimulus: assert rst asynchronously between edges.
    - Required: outputs clear immediately without waiting for clk.
